ps_mul_seq: RTL and testbench

PS_MUL_SEQ -- requirements
Module: ps_mul_seq

---
 rtl/ps_mul_seq.sv | 149 ++++++++++++++
 tb/tb_ps_mul_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps_mul_seq.sv
// ps_mul_seq: decode/execute sequencer for the PS multiplier.
// Accepts one 13-bit multiplier instruction per cycle into a decode
// register, evaluates its condition against live or forwarded flags,
// issues it to the multiplier, then writes back Rn and updates the
// multiplier status flags in the following (execute) cycle.
module ps_mul_seq #(
  parameter int unsigned RF_ADDRSIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_vld,
  input  logic [12:0]            instr_word,
  input  logic                   stall,
  input  logic                   clr_sticky,
  input  logic                   mul_ps_mv,
  input  logic                   mul_ps_mn,
  output logic                   instr_rdy,
  output logic                   ps_mul_en,
  output logic                   ps_mul_otreg,
  output logic [3:0]             ps_mul_dtsts,
  output logic [1:0]             ps_mul_cls,
  output logic                   ps_rf_wen,
  output logic [RF_ADDRSIZE-1:0] ps_rf_waddr,
  output logic                   astat_mv,
  output logic                   astat_mn,
  output logic                   sticky_mos,
  output logic                   ps_illegal
);

  localparam int unsigned INSTR_W = 13;
  localparam int unsigned RN_W    = 4;

  localparam logic [1:0] CLS_SAT     = 2'b00;
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_MV_CLR = 2'b01;
  localparam logic [1:0] COND_MN_SET = 2'b10;

  // decode stage
  logic [INSTR_W-1:0] d_word;
  logic               d_vld;

  // execute stage
  logic               e_vld;
  logic               e_otreg;
  logic [1:0]         e_cls;
  logic [RN_W-1:0]    e_rn;

  logic [1:0]         d_cls;
  logic               d_otreg;
  logic [3:0]         d_dtsts;
  logic [1:0]         d_cond;
  logic [RN_W-1:0]    d_rn;
  logic               accept;
  logic               legal;
  logic               cond_true;
  logic               flag_mv;
  logic               flag_mn;
  logic               decode_live;

  // Field split, legality, condition evaluation and issue decisions
  always_comb begin
    d_cls       = d_word[12:11];
    d_otreg     = d_word[10];
    d_dtsts     = d_word[9:6];
    d_cond      = d_word[5:4];
    d_rn        = d_word[3:0];

    instr_rdy   = ~stall & ~reset;
    accept      = instr_vld & instr_rdy;

    // SAT must target MR; rounding (R) is only meaningful on fractional (F) data
    legal       = ~(((d_cls == CLS_SAT) && !d_otreg) || (d_dtsts[0] && !d_dtsts[1]));

    // An instruction in execute has not written ASTAT yet: use its flags directly
    flag_mv     = e_vld ? mul_ps_mv : astat_mv;
    flag_mn     = e_vld ? mul_ps_mn : astat_mn;

    cond_true   = 1'b0;
    case (d_cond)
      COND_ALWAYS: cond_true = 1'b1;
      COND_MV_CLR: cond_true = ~flag_mv;
      COND_MN_SET: cond_true = flag_mn;
      default:     cond_true = ~flag_mn;
    endcase

    decode_live  = d_vld & ~stall & ~reset & cond_true;
    ps_mul_en    = decode_live & legal;
    ps_illegal   = decode_live & ~legal;
    ps_mul_cls   = d_cls;
    ps_mul_otreg = d_otreg;
    ps_mul_dtsts = d_dtsts;

    ps_rf_wen    = e_vld & ~e_otreg & (e_cls != CLS_SAT) & ~reset;
    ps_rf_waddr  = RF_ADDRSIZE'(e_rn);
  end

  // Decode register: capture on accept, hold while stalled, otherwise empty
  always_ff @(posedge clk) begin
    if (reset) begin
      d_vld  <= 1'b0;
      d_word <= '0;
    end else if (accept) begin
      d_vld  <= 1'b1;
      d_word <= instr_word;
    end else if (!stall) begin
      d_vld  <= 1'b0;
    end
  end

  // Execute register: loaded by an issued instruction, drains every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      e_vld   <= 1'b0;
      e_otreg <= 1'b0;
      e_cls   <= '0;
      e_rn    <= '0;
    end else begin
      e_vld <= ps_mul_en;
      if (ps_mul_en) begin
        e_otreg <= d_otreg;
        e_cls   <= d_cls;
        e_rn    <= d_rn;
      end
    end
  end

  // Status flags: latch multiplier flags at the end of each execute cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      astat_mv <= 1'b0;
      astat_mn <= 1'b0;
    end else if (e_vld) begin
      astat_mv <= mul_ps_mv;
      astat_mn <= mul_ps_mn;
    end
  end

  // Sticky overflow: a new overflow takes priority over a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_mos <= 1'b0;
    end else if (e_vld && mul_ps_mv) begin
      sticky_mos <= 1'b1;
    end else if (clr_sticky) begin
      sticky_mos <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps_mul_seq.sv
// Directed bench for ps_mul_seq: Rn write-backs are checked through a
// scoreboard queue, everything else by direct comparisons per cycle.
module tb_ps_mul_seq;

  localparam int unsigned RF_ADDRSIZE = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   instr_vld;
  logic [12:0]            instr_word;
  logic                   stall;
  logic                   clr_sticky;
  logic                   mul_ps_mv;
  logic                   mul_ps_mn;
  logic                   instr_rdy;
  logic                   ps_mul_en;
  logic                   ps_mul_otreg;
  logic [3:0]             ps_mul_dtsts;
  logic [1:0]             ps_mul_cls;
  logic                   ps_rf_wen;
  logic [RF_ADDRSIZE-1:0] ps_rf_waddr;
  logic                   astat_mv;
  logic                   astat_mn;
  logic                   sticky_mos;
  logic                   ps_illegal;

  int total = 0;
  int bad   = 0;
  int sb[$];

  ps_mul_seq #(.RF_ADDRSIZE(RF_ADDRSIZE)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_vld    (instr_vld),
    .instr_word   (instr_word),
    .stall        (stall),
    .clr_sticky   (clr_sticky),
    .mul_ps_mv    (mul_ps_mv),
    .mul_ps_mn    (mul_ps_mn),
    .instr_rdy    (instr_rdy),
    .ps_mul_en    (ps_mul_en),
    .ps_mul_otreg (ps_mul_otreg),
    .ps_mul_dtsts (ps_mul_dtsts),
    .ps_mul_cls   (ps_mul_cls),
    .ps_rf_wen    (ps_rf_wen),
    .ps_rf_waddr  (ps_rf_waddr),
    .astat_mv     (astat_mv),
    .astat_mn     (astat_mn),
    .sticky_mos   (sticky_mos),
    .ps_illegal   (ps_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard any write-back in the current cycle, then advance one clock
  task automatic next();
    int exp_addr;
    if (ps_rf_wen === 1'b1 && reset === 1'b0) begin
      chk("wb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_addr = sb.pop_front();
        chk("wb_addr", 32'(ps_rf_waddr), 32'(exp_addr));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_vld = 1'b0; instr_word = '0; stall = 1'b0;
    clr_sticky = 1'b0; mul_ps_mv = 1'b0; mul_ps_mn = 1'b0;

    // reset state
    @(posedge clk); #1;
    chk("rst_rdy", 32'(instr_rdy), 0);
    chk("rst_en", 32'(ps_mul_en), 0);
    chk("rst_cls", 32'(ps_mul_cls), 0);
    chk("rst_dtsts", 32'(ps_mul_dtsts), 0);
    chk("rst_wen", 32'(ps_rf_wen), 0);
    chk("rst_mv", 32'(astat_mv), 0);
    chk("rst_sticky", 32'(sticky_mos), 0);
    chk("rst_illegal", 32'(ps_illegal), 0);
    next();
    reset = 1'b0;

    // product to R5, then conditional MV==0 back-to-back (forwarded MV=1 drops it)
    instr_vld = 1'b1; instr_word = 13'h0B85; sb.push_back(5); #1;
    chk("a_rdy", 32'(instr_rdy), 1);
    next();
    instr_word = 13'h0990; #1;
    chk("a_en", 32'(ps_mul_en), 1);
    chk("a_cls", 32'(ps_mul_cls), 1);
    chk("a_dtsts", 32'(ps_mul_dtsts), 32'hE);
    chk("a_otreg", 32'(ps_mul_otreg), 0);
    next();
    instr_vld = 1'b0; mul_ps_mv = 1'b1; #1;
    chk("a_wen", 32'(ps_rf_wen), 1);
    chk("a_fwd_en", 32'(ps_mul_en), 0);
    chk("a_fwd_ill", 32'(ps_illegal), 0);
    next();
    mul_ps_mv = 1'b0; #1;
    chk("a_astat_mv", 32'(astat_mv), 1);
    chk("a_sticky", 32'(sticky_mos), 1);
    chk("a_wen_off", 32'(ps_rf_wen), 0);
    next();

    // sticky: set wins over a simultaneous clear, clear alone works
    instr_vld = 1'b1; instr_word = 13'h0B83; sb.push_back(3); #1;
    next();
    instr_vld = 1'b0; #1;
    chk("s_en", 32'(ps_mul_en), 1);
    next();
    mul_ps_mv = 1'b1; clr_sticky = 1'b1; #1;
    chk("s_wen", 32'(ps_rf_wen), 1);
    next();
    mul_ps_mv = 1'b0; #1;
    chk("s_set_wins", 32'(sticky_mos), 1);
    next();
    clr_sticky = 1'b0; #1;
    chk("s_cleared", 32'(sticky_mos), 0);
    chk("s_astat_mv", 32'(astat_mv), 1);
    next();

    // MN conditions: cond MN==1 false, then cond MN==0 true to R7
    instr_vld = 1'b1; instr_word = 13'h0BA7; #1;
    next();
    instr_word = 13'h0BB7; sb.push_back(7); #1;
    chk("c_mn1_en", 32'(ps_mul_en), 0);
    chk("c_mn1_ill", 32'(ps_illegal), 0);
    next();
    instr_vld = 1'b0; #1;
    chk("c_mn0_en", 32'(ps_mul_en), 1);
    next();
    #1;
    chk("c_wen", 32'(ps_rf_wen), 1);
    next();

    // MAC add to MR: issues but no register write
    instr_vld = 1'b1; instr_word = 13'h1782; #1;
    next();
    instr_vld = 1'b0; #1;
    chk("m_en", 32'(ps_mul_en), 1);
    chk("m_cls", 32'(ps_mul_cls), 2);
    chk("m_otreg", 32'(ps_mul_otreg), 1);
    next();
    #1;
    chk("m_no_wen", 32'(ps_rf_wen), 0);
    next();

    // illegal: SAT to Rn, then R without F; flags must not move
    instr_vld = 1'b1; instr_word = 13'h0000; mul_ps_mv = 1'b1; mul_ps_mn = 1'b1; #1;
    next();
    instr_vld = 1'b0; #1;
    chk("i_sat_en", 32'(ps_mul_en), 0);
    chk("i_sat_ill", 32'(ps_illegal), 1);
    next();
    #1;
    chk("i_one_cycle", 32'(ps_illegal), 0);
    next();
    instr_vld = 1'b1; instr_word = 13'h0841; #1;
    next();
    instr_vld = 1'b0; #1;
    chk("i_rnof_ill", 32'(ps_illegal), 1);
    chk("i_rnof_en", 32'(ps_mul_en), 0);
    next();
    mul_ps_mv = 1'b0; mul_ps_mn = 1'b0; #1;
    chk("i_astat_mv", 32'(astat_mv), 0);
    chk("i_astat_mn", 32'(astat_mn), 0);
    chk("i_sticky", 32'(sticky_mos), 0);
    next();

    // stall three cycles in decode: hold, no accept, issue after release
    instr_vld = 1'b1; instr_word = 13'h0B84; sb.push_back(4); #1;
    next();
    instr_word = 13'h0B89; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t_en", 32'(ps_mul_en), 0);
      chk("t_rdy", 32'(instr_rdy), 0);
      chk("t_dtsts", 32'(ps_mul_dtsts), 32'hE);
      next();
    end
    stall = 1'b0; instr_vld = 1'b0; #1;
    chk("t_release_en", 32'(ps_mul_en), 1);
    next();
    mul_ps_mv = 1'b1; mul_ps_mn = 1'b1; #1;
    chk("t_wen", 32'(ps_rf_wen), 1);
    next();
    mul_ps_mv = 1'b0; mul_ps_mn = 1'b0; #1;
    chk("t_astat_mv", 32'(astat_mv), 1);
    chk("t_astat_mn", 32'(astat_mn), 1);
    next();

    // reset during execute discards the write-back and clears flags
    instr_vld = 1'b1; instr_word = 13'h0B86; #1;
    next();
    instr_vld = 1'b0; #1;
    chk("r_en", 32'(ps_mul_en), 1);
    next();
    reset = 1'b1; mul_ps_mv = 1'b1; mul_ps_mn = 1'b1; #1;
    chk("r_rdy", 32'(instr_rdy), 0);
    next();
    reset = 1'b0; mul_ps_mv = 1'b0; mul_ps_mn = 1'b0; #1;
    chk("r_wen", 32'(ps_rf_wen), 0);
    chk("r_astat_mv", 32'(astat_mv), 0);
    chk("r_astat_mn", 32'(astat_mn), 0);
    chk("r_sticky", 32'(sticky_mos), 0);
    next();
    #1;
    chk("r_wen_after", 32'(ps_rf_wen), 0);
    next();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
